// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg7_pkg;

  // Two-bit index of the digit currently being scanned (0 = rightmost).
  typedef logic [1:0] digit_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low abcdefg patterns, bit 6 = a ... bit 0 = g, indexed by nibble.
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Pure table lookup; the scanner registers the result.
  always_comb begin
    seg = HEX[nib];
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit seven-segment driver with hold register,
// per-slot guard blanking and optional leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CNT_W = 17,
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] x,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  a_to_g,
  output logic [3:0]  an,
  output logic        dp
);

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-3:0] GUARD_POS = GUARD[CNT_W-3:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      x_r_q, x_r_d;
  logic [3:0]       dp_r_q, dp_r_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  digit_t           sel;
  logic [CNT_W-3:0] pos;
  logic [3:0]       nib;
  logic [6:0]       seg_dec;
  logic [3:0]       lz_blank;

  assign sel = cnt_q[CNT_W-1:CNT_W-2];
  assign pos = cnt_q[CNT_W-3:0];

  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 always shows, so a zero word still displays "0".
  assign lz_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign lz_blank[gi] = blank_lz && (x_r_q[15:4*gi] == '0);
    end
  endgenerate

  // Select the held nibble for the digit in the current slot.
  always_comb begin
    nib = x_r_q[3:0];
    case (sel)
      2'd0: nib = x_r_q[3:0];
      2'd1: nib = x_r_q[7:4];
      2'd2: nib = x_r_q[11:8];
      2'd3: nib = x_r_q[15:12];
      default: nib = x_r_q[3:0];
    endcase
  end

  seg7_decode u_decode (
    .nib (nib),
    .seg (seg_dec)
  );

  // Next-state: free-running counter, load-gated hold, output pattern.
  always_comb begin
    cnt_d  = cnt_q + CNT_ONE;
    x_r_d  = load ? x     : x_r_q;
    dp_r_d = load ? dp_in : dp_r_q;
    if ((pos < GUARD_POS) || lz_blank[sel]) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << sel);
      seg_d = seg_dec;
      dp_d  = ~dp_r_q[sel];
    end
  end

  // State and output registers; clr wins over load.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q  <= '0;
      x_r_q  <= '0;
      dp_r_q <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      x_r_q  <= x_r_d;
      dp_r_q <= dp_r_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign a_to_g = seg_q;
  assign an     = an_q;
  assign dp     = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised and directed bench for seg7_scan against a behavioural model.
module tb_seg7_scan;

  localparam int CNT_W  = 4;
  localparam int GUARD  = 1;
  localparam int SLOT   = 1 << (CNT_W - 2);
  localparam int PERIOD = 1 << CNT_W;

  localparam logic [6:0] REF_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] x = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  a_to_g;
  logic [3:0]  an;
  logic        dp;

  int n_vec = 0;
  int n_err = 0;

  // Model state: scan position, held word and held decimal points.
  int          m_cnt = 0;
  logic [15:0] m_xr  = '0;
  logic [3:0]  m_dp  = '0;

  seg7_scan #(.CNT_W(CNT_W), .GUARD(GUARD)) dut (
    .clk      (clk),
    .clr      (clr),
    .x        (x),
    .load     (load),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .a_to_g   (a_to_g),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h (cnt=%0d x_r=%h)", tag, $time, got, exp, m_cnt, m_xr);
    end
  endtask

  // One clock: predict outputs from the model as it stands, advance, compare.
  task automatic step();
    int          sel;
    int          pos;
    logic [15:0] upper;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    e_an  = 4'b1111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    if (!clr) begin
      sel   = m_cnt / SLOT;
      pos   = m_cnt % SLOT;
      upper = m_xr >> (4 * sel);
      if (pos >= GUARD && !(blank_lz && sel != 0 && upper == 16'd0)) begin
        e_an  = ~(4'b0001 << sel);
        e_seg = REF_HEX[upper[3:0]];
        e_dp  = ~m_dp[sel];
      end
    end
    @(posedge clk);
    if (clr) begin
      m_cnt = 0;
      m_xr  = '0;
      m_dp  = '0;
    end else begin
      m_cnt = (m_cnt + 1) % PERIOD;
      if (load) begin
        m_xr = x;
        m_dp = dp_in;
      end
    end
    #1;
    check("an", {12'd0, an}, {12'd0, e_an});
    check("a_to_g", {9'd0, a_to_g}, {9'd0, e_seg});
    check("dp", {15'd0, dp}, {15'd0, e_dp});
    check("one_anode", {15'd0, ($countones(~an) <= 1)}, 16'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model reaches the given counter value (at most a period).
  task automatic run_to(input int c);
    for (int i = 0; i < PERIOD && m_cnt != c; i++) step();
  endtask

  initial begin
    // Reset held for 3 cycles while load tries to capture FFFF.
    clr = 1'b1; load = 1'b1; x = 16'hFFFF; dp_in = 4'hF;
    run(3);
    check("rst_an", {12'd0, an}, 16'h000F);
    clr = 1'b0; load = 1'b0; blank_lz = 1'b0;
    run(PERIOD);

    // Basic scan of 1234.
    x = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    run(2 * PERIOD);

    // Product display with a decimal point on digit 2.
    x = 16'hF32D; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    run(2 * PERIOD);

    // Leading-zero blanking.
    blank_lz = 1'b1; x = 16'h0007; dp_in = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    run(PERIOD);
    x = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;
    run(PERIOD);
    blank_lz = 1'b0;
    run(PERIOD);

    // Hold: input changes without load.
    x = 16'hABCD;
    run(PERIOD);

    // Load mid-slot while digit 2 is on screen.
    run_to(2 * SLOT + 1);
    load = 1'b1; dp_in = 4'b0010;
    step();
    load = 1'b0;
    run(PERIOD);

    // Reset mid-slot, then resume and wrap several times.
    run_to(SLOT + 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    run(40);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      x     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) x[15:4] = 12'h000;
      dp_in = 4'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      clr   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      step();
    end
    clr = 1'b0; load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
